// File: rtl/parity_rr_arbiter.sv
// parity_rr_arbiter
//   Shares one W-bit XOR-chain parity unit among NREQ requesters.
//   A round-robin arbiter accepts one word at a time over a valid/ready
//   handshake. It computes the word's parity in a single calculation cycle
//   and returns the word, its parity and the requester index through a
//   valid/ready response port.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   req_valid  : [NREQ]   requester i presents a word
//   req_data   : [NREQ*W] requester i's word at [i*W +: W]
//   req_ready  : [NREQ]   one-hot grant, combinational, only in IDLE
//   rsp_valid  : response available
//   rsp_id     : [IDW]    index of the requester served
//   rsp_data   : [W]      captured word
//   rsp_parity : XOR of all bits of rsp_data
//   rsp_ready  : consumer accepts the response
//   busy       : high whenever the FSM is not in IDLE
module parity_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_parity,
  input  logic              rsp_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_next_s;
  logic [IDW-1:0] last_grant_r;
  logic [IDW-1:0] cap_id_r;
  logic [W-1:0]   cap_data_r;
  logic [IDW-1:0] grant_s;
  logic           any_s;
  logic [W-1:0]   sel_data_s;

  // Chained XOR: p0 = d0^d1, p1 = p0^d2, ... (1 = odd number of ones).
  function automatic logic parity_of(input logic [W-1:0] d);
    logic p;
    p = d[0];
    for (int i = 1; i < W; i++) begin
      p = p ^ d[i];
    end
    return p;
  endfunction

  // Candidate index at rotation offset k after the last grant, with wrap.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] last, input int k);
    int sum;
    sum = (int'(last) + k) % NREQ;
    return IDW'(sum);
  endfunction

  // Round-robin search: first valid requester after last_grant_r.
  always_comb begin
    grant_s = '0;
    any_s   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!any_s && req_valid[rr_index(last_grant_r, k)]) begin
        any_s   = 1'b1;
        grant_s = rr_index(last_grant_r, k);
      end else begin
        any_s = any_s;
      end
    end
    sel_data_s = req_data[grant_s*W +: W];
  end

  // One-hot grant, only offered while IDLE.
  always_comb begin
    req_ready = '0;
    if (state_r == IDLE && any_s) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state logic for IDLE -> CALC -> RESP -> IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: state_next_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register, capture path and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= IDW'(NREQ - 1);
      cap_id_r     <= '0;
      cap_data_r   <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_data     <= '0;
      rsp_parity   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy    <= (state_next_s != IDLE);
      case (state_r)
        IDLE: begin
          if (any_s) begin
            cap_data_r   <= sel_data_s;
            cap_id_r     <= grant_s;
            last_grant_r <= grant_s;
          end
        end
        CALC: begin
          rsp_data   <= cap_data_r;
          rsp_id     <= cap_id_r;
          rsp_parity <= parity_of(cap_data_r);
          rsp_valid  <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_rr_arbiter.sv
// tb_parity_rr_arbiter
//   Self-checking bench for parity_rr_arbiter. A transaction-level reference
//   model keeps a queue of accepted words, each stamped with the cycle at
//   which its response becomes visible; expected parity is the reduction XOR.
module tb_parity_rr_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_parity;
  logic              rsp_ready;
  logic              busy;

  parity_rr_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_parity (rsp_parity),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [W-1:0] data;
    logic        par;
    int          valid_at;
  } txn_t;

  txn_t            exp_q[$];
  int              last_m;
  int              cyc;
  int              errors = 0;
  int              checks = 0;
  logic [NREQ-1:0] obs_ready;
  logic            obs_rsp_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_m = NREQ - 1;
    cyc    = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance.
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] d, input logic rr);
    logic [NREQ-1:0] exp_ready;
    logic            exp_v;
    int              g;
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    rsp_ready = rr;
    #1;
    exp_ready = '0;
    g = -1;
    if (exp_q.size() == 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (g < 0 && v[(last_m + k) % NREQ]) g = (last_m + k) % NREQ;
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    exp_v = (exp_q.size() != 0) && (cyc >= exp_q[0].valid_at);
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("busy", 32'(busy), 32'(exp_q.size() != 0));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (exp_v) begin
      check("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
      check("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
      check("rsp_parity", 32'(rsp_parity), 32'(exp_q[0].par));
    end
    obs_ready     = req_ready;
    obs_rsp_valid = rsp_valid;
    @(posedge clk);
    if (g >= 0) begin
      txn_t t;
      t.id       = g;
      t.data     = d[g*W +: W];
      t.par      = ^d[g*W +: W];
      t.valid_at = cyc + 2;
      exp_q.push_back(t);
      last_m = g;
    end else if (exp_v && rr) begin
      void'(exp_q.pop_front());
    end
    cyc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_fields", {27'd0, rsp_parity, rsp_data}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [NREQ*W-1:0] put(input int i, input logic [W-1:0] w);
    logic [NREQ*W-1:0] d;
    d = NREQ*W'($urandom());
    d[i*W +: W] = w;
    return d;
  endfunction

  // Run one word from requester i to completion and check its parity.
  task automatic run_one(input int i, input logic [W-1:0] w, input logic par_exp);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    step(v, put(i, w), 1'b1);
    check("sweep_grant", 32'(obs_ready), 32'(v));
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    check("sweep_parity", 32'(rsp_parity), 32'(par_exp));
    step('0, '0, 1'b1);
  endtask

  initial begin
    int grants[$];
    int gcyc[$];
    logic [NREQ-1:0] v;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    model_reset();
    apply_reset();

    // Test 1: first priority to requester 0.
    step(4'b0101, NREQ*W'($urandom()), 1'b1);
    check("t1_grant0", 32'(obs_ready), 32'h1);
    repeat (3) step('0, '0, 1'b1);

    // Test 2: requester 2 only, data 1011.
    step(4'b0100, put(2, 4'b1011), 1'b1);
    check("t2_grant2", 32'(obs_ready), 32'h4);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    check("t2_rsp_valid", 32'(obs_rsp_valid), 32'd1);
    check("t2_rsp_id", 32'(rsp_id), 32'd2);
    check("t2_rsp_data", 32'(rsp_data), 32'hB);
    check("t2_parity", 32'(rsp_parity), 32'd1);
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);

    // Test 3: all valid, strict rotation one grant every 3 cycles.
    apply_reset();
    for (int n = 0; n < 15; n++) begin
      step(4'b1111, NREQ*W'($urandom()), 1'b1);
      for (int i = 0; i < NREQ; i++) begin
        if (obs_ready == NREQ'(1 << i)) begin
          grants.push_back(i);
          gcyc.push_back(n);
        end
      end
    end
    check("t3_grant_count", 32'(grants.size()), 32'd5);
    for (int j = 0; j < 5 && j < grants.size(); j++) begin
      check("t3_rotation", 32'(grants[j]), 32'(j % NREQ));
      if (j > 0) check("t3_spacing", 32'(gcyc[j] - gcyc[j-1]), 32'd3);
    end
    repeat (3) step('0, '0, 1'b1);

    // Test 4: backpressure in RESP holds everything stable.
    step(4'b0001, put(0, 4'b0110), 1'b0);
    step(4'b1111, '1, 1'b0);
    repeat (5) step(4'b1111, NREQ*W'($urandom()), 1'b0);
    check("t4_hold_valid", 32'(obs_rsp_valid), 32'd1);
    check("t4_hold_data", 32'(rsp_data), 32'h6);
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);
    check("t4_drop_valid", 32'(obs_rsp_valid), 32'd0);

    // Test 5: reset while requester 3's word is in CALC.
    repeat (2) step('0, '0, 1'b1);
    step(4'b1000, put(3, 4'b1110), 1'b1);
    check("t5_grant3", 32'(obs_ready), 32'h8);
    apply_reset();
    repeat (4) begin
      step('0, '0, 1'b1);
      check("t5_no_rsp", 32'(obs_rsp_valid), 32'd0);
    end
    step(4'b1100, NREQ*W'($urandom()), 1'b1);
    check("t5_grant2", 32'(obs_ready), 32'h4);
    repeat (3) step('0, '0, 1'b1);

    // Test 6: parity sweep on requester 1.
    run_one(1, 4'b0000, 1'b0);
    run_one(1, 4'b1111, 1'b0);
    run_one(1, 4'b0001, 1'b1);
    run_one(1, 4'b0111, 1'b1);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      v = NREQ'($urandom());
      step(v, NREQ*W'($urandom()), ($urandom_range(0, 3) != 0));
      if (n == 200) apply_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
